// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line responder: receives 48-bit host commands and answers the identification sequence.
// Optional build macro SD_RESP_CRC_CHECK_EN: drop commands whose CRC7 does not match and flag crc_err.
module sd_card_cmd_responder #(
  parameter logic [15:0]  RCA         = 16'hF792,
  parameter logic [31:0]  OCR         = 32'h00FF8000,
  parameter logic [119:0] CID         = 120'hAFE53C7AB12900000ECD,
  parameter int unsigned  BUSY_ROUNDS = 2,
  parameter int unsigned  NCR         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_clk_tick,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  output logic        illegal_cmd,
  output logic [1:0]  card_state
);

`ifdef SD_RESP_CRC_CHECK_EN
  localparam bit CRC_CHECK = 1'b1;
`else
  localparam bit CRC_CHECK = 1'b0;
`endif

  localparam logic [7:0] BUSY_LIM = 8'(BUSY_ROUNDS);
  localparam logic [7:0] NCR_LAST = 8'(NCR - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_BITS, DECODE, WAIT_NCR, TX_BITS} line_t;
  typedef enum logic [1:0] {ST_IDLE, ST_READY, ST_IDENT, ST_STBY} card_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  line_t        line;
  card_t        st;
  logic [47:0]  rx_frame;
  logic [5:0]   rx_cnt;
  logic [6:0]   rx_crc;
  logic         app;
  logic [7:0]   busy_cnt;
  logic [7:0]   ncr_cnt;
  logic [135:0] tx_data;
  logic [7:0]   tx_idx, tx_len, tx_lo, tx_hi;
  logic         tx_use_crc;
  logic [6:0]   tx_crc;
  logic         crc_err_q;

  card_t        st_next;
  logic [7:0]   busy_next;
  logic         app_next, dec_illegal;
  logic         resp_en, resp_use_crc;
  logic [135:0] resp_data;
  logic [7:0]   resp_len, resp_lo, resp_hi;
  logic [31:0]  r1_status;
  logic         acmd_ready, frame_ok, crc_bad;
  logic         in_crc_msg, in_crc_slot, tx_bit, drive;

  assign card_state = st;
  assign crc_err    = crc_err_q;
  assign acmd_ready = (busy_cnt >= BUSY_LIM);
  assign frame_ok   = !rx_frame[47] && rx_frame[46] && rx_frame[0];
  assign crc_bad    = CRC_CHECK && (rx_crc != rx_frame[7:1]);
  // R1 is only sent for CMD55, so the reported app flag is the freshly set one
  assign r1_status  = {19'b0, 2'b00, st, 3'b0, 1'b1, 5'b0};

  always_comb begin
    st_next      = st;
    busy_next    = busy_cnt;
    app_next     = 1'b0;
    dec_illegal  = 1'b0;
    resp_en      = 1'b0;
    resp_use_crc = 1'b1;
    resp_data    = '0;
    resp_len     = 8'd48;
    resp_lo      = 8'd0;
    resp_hi      = 8'd40;
    case (rx_frame[45:40])
      6'd0: begin
        st_next   = ST_IDLE;
        busy_next = '0;
      end
      6'd55: begin
        app_next  = 1'b1;
        resp_en   = 1'b1;
        resp_data = {2'b00, 6'd55, r1_status, 7'h00, 1'b1, 88'h0};
      end
      6'd41: begin
        if (app && st == ST_IDLE) begin
          resp_en      = 1'b1;
          resp_use_crc = 1'b0;
          resp_data    = {2'b00, 6'h3F, acmd_ready, OCR[30:0], 7'h7F, 1'b1, 88'h0};
          if (acmd_ready) st_next = ST_READY;
          else            busy_next = busy_cnt + 8'd1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'd2: begin
        if (st == ST_READY) begin
          resp_en   = 1'b1;
          resp_len  = 8'd136;
          resp_lo   = 8'd8;
          resp_hi   = 8'd128;
          resp_data = {2'b00, 6'h3F, CID, 7'h00, 1'b1};
          st_next   = ST_IDENT;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'd3: begin
        if (st == ST_IDENT || st == ST_STBY) begin
          resp_en   = 1'b1;
          resp_data = {2'b00, 6'd3, RCA, 16'h0000, 7'h00, 1'b1, 88'h0};
          st_next   = ST_STBY;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // CRC slot positions hold zeros in tx_data; the running CRC is substituted there
  assign in_crc_msg  = tx_use_crc && (tx_idx >= tx_lo) && (tx_idx < tx_hi);
  assign in_crc_slot = tx_use_crc && (tx_idx >= tx_hi) && (tx_idx < tx_hi + 8'd7);
  assign tx_bit      = in_crc_slot ? tx_crc[6] : tx_data[135];
  assign drive       = sd_clk_tick &&
                       ((line == WAIT_NCR && ncr_cnt == NCR_LAST) ||
                        (line == TX_BITS && tx_idx != tx_len));

  always_ff @(posedge clk) begin
    if (reset) begin
      line        <= RX_IDLE;
      st          <= ST_IDLE;
      cmd_out     <= 1'b1;
      cmd_oe      <= 1'b0;
      cmd_valid   <= 1'b0;
      crc_err_q   <= 1'b0;
      illegal_cmd <= 1'b0;
      cmd_index   <= '0;
      cmd_arg     <= '0;
      app         <= 1'b0;
      busy_cnt    <= '0;
      rx_frame    <= '0;
      rx_cnt      <= '0;
      rx_crc      <= '0;
      ncr_cnt     <= '0;
      tx_data     <= '0;
      tx_idx      <= '0;
      tx_len      <= '0;
      tx_lo       <= '0;
      tx_hi       <= '0;
      tx_use_crc  <= 1'b0;
      tx_crc      <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      crc_err_q   <= 1'b0;
      illegal_cmd <= 1'b0;
      case (line)
        RX_IDLE: begin
          if (sd_clk_tick && !cmd_in) begin
            rx_frame <= '0;
            rx_crc   <= '0;
            rx_cnt   <= 6'd1;
            line     <= RX_BITS;
          end
        end
        RX_BITS: begin
          if (sd_clk_tick) begin
            rx_frame <= {rx_frame[46:0], cmd_in};
            if (rx_cnt < 6'd40) rx_crc <= crc7_step(rx_crc, cmd_in);
            rx_cnt <= rx_cnt + 6'd1;
            if (rx_cnt == 6'd47) line <= DECODE;
          end
        end
        DECODE: begin
          line <= RX_IDLE;
          if (frame_ok) begin
            cmd_index <= rx_frame[45:40];
            cmd_arg   <= rx_frame[39:8];
            if (crc_bad) begin
              crc_err_q <= 1'b1;
            end else begin
              cmd_valid   <= 1'b1;
              illegal_cmd <= dec_illegal;
              st          <= st_next;
              busy_cnt    <= busy_next;
              app         <= app_next;
              if (resp_en) begin
                // a tick landing in this cycle already counts toward NCR
                ncr_cnt    <= {7'b0, sd_clk_tick};
                tx_data    <= resp_data;
                tx_len     <= resp_len;
                tx_lo      <= resp_lo;
                tx_hi      <= resp_hi;
                tx_use_crc <= resp_use_crc;
                tx_idx     <= '0;
                tx_crc     <= '0;
                line       <= WAIT_NCR;
              end
            end
          end
        end
        WAIT_NCR: begin
          if (sd_clk_tick) ncr_cnt <= ncr_cnt + 8'd1;
        end
        TX_BITS: begin
          if (sd_clk_tick && tx_idx == tx_len) begin
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
            line    <= RX_IDLE;
          end
        end
        default: line <= RX_IDLE;
      endcase
      if (drive) begin
        cmd_oe  <= 1'b1;
        cmd_out <= tx_bit;
        tx_data <= tx_data << 1;
        tx_idx  <= tx_idx + 8'd1;
        if (in_crc_msg)       tx_crc <= crc7_step(tx_crc, tx_bit);
        else if (in_crc_slot) tx_crc <= {tx_crc[5:0], 1'b0};
        line    <= TX_BITS;
      end
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Randomized bench for sd_card_cmd_responder with a protocol-level reference model.
// Honours SD_RESP_CRC_CHECK_EN in the model when the macro is defined for the build.
module tb_sd_card_cmd_responder;

  localparam logic [15:0]  RCA         = 16'hF792;
  localparam logic [31:0]  OCR         = 32'h00FF8000;
  localparam logic [119:0] CID         = 120'hAFE53C7AB12900000ECD;
  localparam int           BUSY_ROUNDS = 2;
  localparam int           NCR         = 2;

`ifdef SD_RESP_CRC_CHECK_EN
  localparam bit CHECK_CRC = 1'b1;
`else
  localparam bit CHECK_CRC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sd_clk_tick = 1'b0;
  logic        cmd_in = 1'b1;
  logic        cmd_out, cmd_oe, cmd_valid, crc_err, illegal_cmd;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  card_state;

  sd_card_cmd_responder #(
    .RCA(RCA), .OCR(OCR), .CID(CID), .BUSY_ROUNDS(BUSY_ROUNDS), .NCR(NCR)
  ) dut (
    .clk(clk), .reset(reset), .sd_clk_tick(sd_clk_tick), .cmd_in(cmd_in),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .cmd_valid(cmd_valid),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .crc_err(crc_err),
    .illegal_cmd(illegal_cmd), .card_state(card_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_crc   = 0;
  int n_ill   = 0;

  always @(negedge clk) begin
    if (cmd_valid)   n_valid++;
    if (crc_err)     n_crc++;
    if (illegal_cmd) n_ill++;
  end

  // reference card model
  int m_state = 0;
  bit m_app   = 1'b0;
  int m_busy  = 0;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 by polynomial long division of m*x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_of(input logic [119:0] m, input int n);
    logic [126:0] r;
    r = {m, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, crc7_of({80'b0, msg}, 40), 1'b1};
  endfunction

  // Drive one sd_clk tick; leaves the bench on a negedge with outputs sampled.
  task automatic do_tick(input logic b, output logic oe, output logic out);
    cmd_in = b;
    sd_clk_tick = 1'b1;
    @(negedge clk);
    oe  = cmd_oe;
    out = cmd_out;
    sd_clk_tick = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_cmd(input logic [47:0] f, input string tag, output logic [135:0] got);
    logic [135:0] exp;
    logic [39:0]  msg;
    logic [31:0]  status, ocr;
    logic [5:0]   idx;
    logic         oe, out;
    int exp_len, glen, first, bound, v0, c0, i0;
    bit framed, crc_ok, exp_valid, exp_crce, exp_ill, started, done, ready;

    exp = '0; exp_len = 0; exp_valid = 0; exp_crce = 0; exp_ill = 0;
    idx    = f[45:40];
    framed = f[46] && f[0];
    crc_ok = (crc7_of({80'b0, f[47:8]}, 40) == f[7:1]);
    if (framed) begin
      if (CHECK_CRC && !crc_ok) begin
        exp_crce = 1;
      end else begin
        exp_valid = 1;
        if (idx == 6'd0) begin
          m_state = 0; m_busy = 0; m_app = 0;
        end else if (idx == 6'd55) begin
          status  = (32'(m_state) << 9) | 32'h20;
          msg     = {2'b00, 6'd55, status};
          exp     = {88'b0, msg, crc7_of({80'b0, msg}, 40), 1'b1};
          exp_len = 48;
          m_app   = 1;
        end else if (idx == 6'd41 && m_app && m_state == 0) begin
          ready   = (m_busy >= BUSY_ROUNDS);
          ocr     = {ready, OCR[30:0]};
          exp     = {88'b0, 2'b00, 6'h3F, ocr, 7'h7F, 1'b1};
          exp_len = 48;
          if (ready) m_state = 1; else m_busy++;
          m_app   = 0;
        end else if (idx == 6'd2 && m_state == 1) begin
          exp     = {2'b00, 6'h3F, CID, crc7_of(CID, 120), 1'b1};
          exp_len = 136;
          m_state = 2;
          m_app   = 0;
        end else if (idx == 6'd3 && m_state >= 2) begin
          msg     = {2'b00, 6'd3, RCA, 16'h0000};
          exp     = {88'b0, msg, crc7_of({80'b0, msg}, 40), 1'b1};
          exp_len = 48;
          m_state = 3;
          m_app   = 0;
        end else begin
          exp_ill = 1;
          m_app   = 0;
        end
      end
    end

    v0 = n_valid; c0 = n_crc; i0 = n_ill;
    for (int i = 47; i >= 0; i--) do_tick(f[i], oe, out);

    got = '0; glen = 0; first = -1; started = 0; done = 0;
    bound = exp_len + NCR + 4;
    for (int t = 1; t <= bound && !done; t++) begin
      do_tick(1'b1, oe, out);
      if (oe) begin
        if (!started) begin
          started = 1;
          first = t;
        end
        got = {got[134:0], out};
        glen++;
      end else if (started) begin
        done = 1;
      end
    end

    if (framed) begin
      check({tag, "_index"}, 136'(cmd_index), 136'(idx));
      check({tag, "_arg"}, 136'(cmd_arg), 136'(f[39:8]));
    end
    if (!exp_ill) check({tag, "_valid"}, 136'(n_valid - v0), 136'(exp_valid));
    check({tag, "_crc_err"}, 136'(n_crc - c0), 136'(exp_crce));
    check({tag, "_illegal"}, 136'(n_ill - i0), 136'(exp_ill));
    check({tag, "_state"}, 136'(card_state), 136'(m_state));
    if (exp_len > 0) begin
      check({tag, "_ncr"}, 136'(first), 136'(NCR));
      check({tag, "_len"}, 136'(glen), 136'(exp_len));
      check({tag, "_oe_drop"}, 136'(done), 136'(1));
      check({tag, "_resp"}, got, exp);
    end else begin
      check({tag, "_no_resp"}, 136'(started), 136'(0));
    end
  endtask

  initial begin
    logic [135:0] r;
    logic [47:0]  f;
    logic         oe, out;
    int           sel, cnt;
    logic [5:0]   idx;
    logic [31:0]  arg;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_oe", 136'(cmd_oe), 136'(0));
    check("rst_out", 136'(cmd_out), 136'(1));
    check("rst_state", 136'(card_state), 136'(0));
    check("rst_index", 136'(cmd_index), 136'(0));
    check("rst_arg", 136'(cmd_arg), 136'(0));
    check("rst_pulses", 136'(n_valid + n_crc + n_ill), 136'(0));

    run_cmd(48'h400000000095, "cmd0", r);
    run_cmd(48'h770000000065, "cmd55", r);
    check("r1_index", 136'(r[45:40]), 136'(55));
    check("r1_status", 136'(r[39:8]), 136'(32'h00000020));

    for (int k = 0; k < 3; k++) begin
      run_cmd(make_frame(6'd55, 32'h0), "pre41", r);
      run_cmd(make_frame(6'd41, 32'h40FF8000), "acmd41", r);
      check("ocr_busy_bit", 136'(r[39]), 136'(k == 2));
    end
    check("ready_state", 136'(card_state), 136'(1));

    run_cmd(make_frame(6'd2, 32'h0), "cmd2", r);
    check("r2_cid", 136'(r[127:8]), 136'(CID));
    run_cmd(make_frame(6'd3, 32'h0), "cmd3", r);
    check("r6_rca", 136'(r[39:24]), 136'(RCA));

    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      arg = $urandom;
      case (sel)
        0:       idx = 6'd0;
        1, 2, 8: idx = 6'd55;
        3, 4:    idx = 6'd41;
        5:       idx = 6'd2;
        6:       idx = 6'd3;
        default: idx = 6'($urandom_range(0, 63));
      endcase
      f = make_frame(idx, arg);
      if (sel == 8) f[1] = ~f[1];
      if (sel == 9) begin
        if ($urandom_range(0, 1) == 0) f[0] = 1'b0;
        else f[46] = 1'b0;
      end
      run_cmd(f, "rand", r);
    end

    run_cmd(48'h400000000095, "pre_rst_cmd0", r);
    for (int k = 0; k < 3; k++) begin
      run_cmd(make_frame(6'd55, 32'h0), "pre_rst_55", r);
      run_cmd(make_frame(6'd41, 32'h40FF8000), "pre_rst_41", r);
    end
    f = make_frame(6'd2, 32'h0);
    for (int i = 47; i >= 0; i--) do_tick(f[i], oe, out);
    cnt = 0;
    for (int t = 0; t < 40 && cnt < 20; t++) begin
      do_tick(1'b1, oe, out);
      if (oe) cnt++;
    end
    check("r2_bits_before_rst", 136'(cnt), 136'(20));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_oe", 136'(cmd_oe), 136'(0));
    check("midrst_out", 136'(cmd_out), 136'(1));
    check("midrst_state", 136'(card_state), 136'(0));
    reset = 1'b0;
    m_state = 0; m_app = 0; m_busy = 0;
    @(negedge clk);
    run_cmd(48'h400000000095, "post_rst_cmd0", r);

    run_cmd(make_frame(6'd2, 32'h0), "cmd2_idle", r);
    run_cmd(48'h770000000065 ^ 48'h2, "cmd55_badcrc", r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
